// File: rtl/alu_shift_sequencer_if.sv
// Request/response handshake plus the ALU drive/return bus of the
// alu_shift_sequencer. The sequencer connects through the slave modport;
// the requester/ALU side uses the master modport.
interface alu_shift_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
);
    // Request channel
    logic             reqValid;
    logic             reqReady;
    logic [3:0]       reqOp;
    logic [WIDTH-1:0] reqA;
    logic [WIDTH-1:0] reqB;
    logic [CNT_W-1:0] reqShiftCount;

    // Response channel
    logic             rspValid;
    logic             rspReady;
    logic [WIDTH-1:0] rspResult;
    logic             rspZero;
    logic             rspCarry;
    logic             busy;

    // ALU drive and return
    logic [WIDTH-1:0] aluOperandA;
    logic [WIDTH-1:0] aluOperandB;
    logic [3:0]       aluOp;
    logic             aluShiftAmount;
    logic             aluEnable;
    logic [WIDTH-1:0] aluRes;
    logic             aluZero;
    logic             aluCarry;

    modport slave (
        input  reqValid, reqOp, reqA, reqB, reqShiftCount, rspReady,
               aluRes, aluZero, aluCarry,
        output reqReady, rspValid, rspResult, rspZero, rspCarry, busy,
               aluOperandA, aluOperandB, aluOp, aluShiftAmount, aluEnable
    );

    modport master (
        output reqValid, reqOp, reqA, reqB, reqShiftCount, rspReady,
               aluRes, aluZero, aluCarry,
        input  reqReady, rspValid, rspResult, rspZero, rspCarry, busy,
               aluOperandA, aluOperandB, aluOp, aluShiftAmount, aluEnable
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle controller in front of a single-cycle ALU. One operation in
// flight at a time: single-cycle ops take one ALU pass, shifts of distance
// N take N passes of the ALU's 1-bit shift. ALU outputs are driven (and the
// ALU enabled) only while a pass is being issued.
module alu_shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_shift_sequencer_if.slave bus
);
    localparam logic [3:0] OP_SLA = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             req_is_shift;

    // Decode whether the offered request is one of the iterated shifts.
    assign req_is_shift = (bus.reqOp == OP_SLA) || (bus.reqOp == OP_SRA) ||
                          (bus.reqOp == OP_SRL);

    // Sequencer FSM with registered outputs. The ALU drive registers double
    // as the latched request: aluOperandA is the shift work register, so no
    // separate copy of op/A/B is kept.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            remaining          <= '0;
            bus.reqReady       <= 1'b1;
            bus.busy           <= 1'b0;
            bus.rspValid       <= 1'b0;
            bus.rspResult      <= '0;
            bus.rspZero        <= 1'b0;
            bus.rspCarry       <= 1'b0;
            bus.aluOperandA    <= '0;
            bus.aluOperandB    <= '0;
            bus.aluOp          <= '0;
            bus.aluShiftAmount <= 1'b0;
            bus.aluEnable      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // reqReady is high throughout IDLE, so reqValid alone is the handshake
                    if (bus.reqValid) begin
                        bus.reqReady <= 1'b0;
                        bus.busy     <= 1'b1;
                        if (!req_is_shift) begin
                            state              <= EXEC;
                            bus.aluOp          <= bus.reqOp;
                            bus.aluOperandA    <= bus.reqA;
                            bus.aluOperandB    <= bus.reqB;
                            bus.aluShiftAmount <= 1'b0;
                            bus.aluEnable      <= 1'b1;
                        end else if (bus.reqShiftCount != '0) begin
                            state              <= SHIFT;
                            remaining          <= bus.reqShiftCount;
                            bus.aluOp          <= bus.reqOp;
                            bus.aluOperandA    <= bus.reqA;
                            bus.aluOperandB    <= '0;
                            bus.aluShiftAmount <= 1'b1;
                            bus.aluEnable      <= 1'b1;
                        end else begin
                            // Zero-distance shift answers directly; the ALU stays off
                            state         <= DONE;
                            bus.rspValid  <= 1'b1;
                            bus.rspResult <= bus.reqA;
                            bus.rspZero   <= (bus.reqA == {WIDTH{1'b0}});
                            bus.rspCarry  <= 1'b0;
                        end
                    end
                end

                EXEC: begin
                    state              <= DONE;
                    bus.rspValid       <= 1'b1;
                    bus.rspResult      <= bus.aluRes;
                    bus.rspZero        <= bus.aluZero;
                    bus.rspCarry       <= bus.aluCarry;
                    bus.aluOperandA    <= '0;
                    bus.aluOperandB    <= '0;
                    bus.aluOp          <= '0;
                    bus.aluShiftAmount <= 1'b0;
                    bus.aluEnable      <= 1'b0;
                end

                SHIFT: begin
                    if (remaining == CNT_W'(1)) begin
                        // Last pass: the shifted-out bit is not reported as carry
                        state              <= DONE;
                        remaining          <= '0;
                        bus.rspValid       <= 1'b1;
                        bus.rspResult      <= bus.aluRes;
                        bus.rspZero        <= bus.aluZero;
                        bus.rspCarry       <= 1'b0;
                        bus.aluOperandA    <= '0;
                        bus.aluOperandB    <= '0;
                        bus.aluOp          <= '0;
                        bus.aluShiftAmount <= 1'b0;
                        bus.aluEnable      <= 1'b0;
                    end else begin
                        bus.aluOperandA <= bus.aluRes;
                        remaining       <= remaining - CNT_W'(1);
                    end
                end

                DONE: begin
                    // Response registers hold until the consumer takes them
                    if (bus.rspReady) begin
                        state        <= IDLE;
                        bus.rspValid <= 1'b0;
                        bus.reqReady <= 1'b1;
                        bus.busy     <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer. A combinational ALU stand-in
// answers the DUT's ALU bus; a transaction-level model tracks cycles since
// accept and predicts every control, ALU-bus and response output per cycle.
module tb_alu_shift_sequencer;
    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SLA = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alu_shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLA) || (op == OP_SRA) || (op == OP_SRL);
    endfunction

    // Single-cycle ALU behaviour: {carry, result}. Shifts move by sh (0 or 1)
    // and report the bit shifted out as carry.
    function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic sh);
        logic [32:0] r;
        case (op)
            OP_ADD: r = {1'b0, a} + {1'b0, b};
            OP_SUB: r = {(a < b), a - b};
            OP_AND: r = {1'b0, a & b};
            OP_OR:  r = {1'b0, a | b};
            OP_XOR: r = {1'b0, a ^ b};
            OP_NOT: r = {1'b0, ~a};
            OP_SLA: r = sh ? {a[31], a << 1} : {1'b0, a};
            OP_SRL: r = sh ? {a[0], a >> 1} : {1'b0, a};
            OP_SRA: r = sh ? {a[0], a[31], a[31:1]} : {1'b0, a};
            default: r = '0;
        endcase
        return r;
    endfunction

    // ALU stand-in on the shared bus: silent when not enabled
    logic [32:0] alu_out;
    assign alu_out      = alu_fn(bus.aluOp, bus.aluOperandA, bus.aluOperandB, bus.aluShiftAmount);
    assign bus.aluRes   = bus.aluEnable ? alu_out[31:0] : '0;
    assign bus.aluZero  = bus.aluEnable && (alu_out[31:0] == 32'd0);
    assign bus.aluCarry = bus.aluEnable && alu_out[32];

    // Whole-distance shift in one step
    function automatic logic [31:0] shifted(input logic [3:0] op, input logic [31:0] a, input int n);
        case (op)
            OP_SLA:  return a << n;
            OP_SRL:  return a >> n;
            OP_SRA:  return $signed(a) >>> n;
            default: return a;
        endcase
    endfunction

    // Final response {result, zero, carry}
    function automatic logic [33:0] expected_rsp(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input int n);
        logic [32:0] r;
        if (is_shift(op)) r = {1'b0, shifted(op, a, n)};
        else              r = alu_fn(op, a, b, 1'b0);
        return {r[31:0], (r[31:0] == 32'd0), r[32]};
    endfunction

    // Transaction model: m_k counts cycles since accept; cycles 1..m_lat are
    // ALU passes, after that the response is presented until taken.
    logic        m_active;
    int          m_k;
    int          m_lat;
    int          m_n;
    logic [3:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
        end else if (!m_active) begin
            if (bus.reqValid) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_op     <= bus.reqOp;
                m_a      <= bus.reqA;
                m_b      <= bus.reqB;
                m_n      <= int'(bus.reqShiftCount);
                m_lat    <= is_shift(bus.reqOp) ? int'(bus.reqShiftCount) : 1;
            end
        end else if (m_k > m_lat) begin
            if (bus.rspReady) m_active <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Per-cycle compare of every DUT output against the model
    always @(negedge clk) begin : compare
        logic        ex;
        logic        sh;
        logic [31:0] ea;
        ex = m_active && (m_k <= m_lat);
        sh = ex && is_shift(m_op);
        ea = ex ? (sh ? shifted(m_op, m_a, m_k - 1) : m_a) : 32'd0;
        check("ctrl{reqReady,busy,rspValid}", {bus.reqReady, bus.busy, bus.rspValid},
              {!m_active, m_active, m_active && (m_k > m_lat)});
        check("alu{enable,shamt,op}", {bus.aluEnable, bus.aluShiftAmount, bus.aluOp},
              {ex, sh, (ex ? m_op : 4'd0)});
        check("aluOperandA", bus.aluOperandA, ea);
        check("aluOperandB", bus.aluOperandB, (ex && !sh) ? m_b : 32'd0);
        if (m_active && (m_k > m_lat))
            check("rsp{result,zero,carry}", {bus.rspResult, bus.rspZero, bus.rspCarry},
                  expected_rsp(m_op, m_a, m_b, m_n));
    end

    // Issue one request, wait for the response, hold it for 'hold' cycles, take it.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] n, input int hold,
                          output int lat, output logic [33:0] rsp);
        @(posedge clk); #1;
        bus.reqValid      = 1'b1;
        bus.reqOp         = op;
        bus.reqA          = a;
        bus.reqB          = b;
        bus.reqShiftCount = n;
        bus.rspReady      = 1'b0;
        @(posedge clk); #1;
        // scramble request fields; they must not matter once accepted
        bus.reqValid      = 1'b0;
        bus.reqOp         = 4'($urandom);
        bus.reqA          = $urandom;
        bus.reqB          = $urandom;
        bus.reqShiftCount = 5'($urandom);
        lat = -1;
        rsp = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus.rspValid) begin
                lat = cyc;
                rsp = {bus.rspResult, bus.rspZero, bus.rspCarry};
                break;
            end
            @(posedge clk);
        end
        check("rspValid_within_budget", (lat > 0), 1'b1);
        if (lat < 0) return;
        repeat (hold) @(posedge clk);
        #1 bus.rspReady = 1'b1;
        @(posedge clk); #1;
        bus.rspReady = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [33:0] rsp;
        logic        seen;
        logic [3:0]  op;
        logic [4:0]  n;

        bus.reqValid      = 1'b0;
        bus.reqOp         = '0;
        bus.reqA          = '0;
        bus.reqB          = '0;
        bus.reqShiftCount = '0;
        bus.rspReady      = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_ctrl{reqReady,busy,rspValid}", {bus.reqReady, bus.busy, bus.rspValid}, 3'b100);
        check("reset_rsp", {bus.rspResult, bus.rspZero, bus.rspCarry}, 34'd0);
        check("reset_alu_enable", bus.aluEnable, 1'b0);
        @(negedge clk); #1 reset = 1'b0;

        // ADD overflow: zero and carry set, response in cycle 2
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0, lat, rsp);
        check("add_latency", lat, 2);
        check("add_rsp", rsp, {32'h0000_0000, 1'b1, 1'b1});

        // SRL by 31
        run_op(OP_SRL, 32'h8000_0000, 32'h1234_5678, 5'd31, 0, lat, rsp);
        check("srl31_latency", lat, 32);
        check("srl31_rsp", rsp, {32'h0000_0001, 1'b0, 1'b0});

        // SRA by 4 replicates the sign
        run_op(OP_SRA, 32'h8000_0000, 32'd0, 5'd4, 0, lat, rsp);
        check("sra4_latency", lat, 5);
        check("sra4_rsp", rsp, {32'hF800_0000, 1'b0, 1'b0});

        // SLA by 31 drops everything but the lsb into the msb
        run_op(OP_SLA, 32'h0000_0001, 32'd0, 5'd31, 0, lat, rsp);
        check("sla31_rsp", rsp, {32'h8000_0000, 1'b0, 1'b0});

        // Zero-distance shift answers in cycle 1 without the ALU
        run_op(OP_SLA, 32'd0, 32'hFFFF_FFFF, 5'd0, 0, lat, rsp);
        check("sla0_latency", lat, 1);
        check("sla0_rsp", rsp, {32'd0, 1'b1, 1'b0});

        // Backpressure with a second request held valid throughout
        @(posedge clk); #1;
        bus.reqValid = 1'b1; bus.reqOp = OP_ADD; bus.reqA = 32'd5; bus.reqB = 32'd7;
        bus.reqShiftCount = 5'd0; bus.rspReady = 1'b0;
        @(posedge clk); #1;
        bus.reqOp = OP_XOR; bus.reqA = 32'hFFFF_0000; bus.reqB = 32'h0000_FFFF;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_first_valid", bus.rspValid, 1'b1);
        check("bp_first_rsp", {bus.rspResult, bus.rspZero, bus.rspCarry}, {32'd12, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_rsp_stable", {bus.rspValid, bus.rspResult, bus.rspZero, bus.rspCarry},
                  {1'b1, 32'd12, 1'b0, 1'b0});
            check("bp_reqReady_low", bus.reqReady, 1'b0);
        end
        #1 bus.rspReady = 1'b1;
        @(posedge clk); #1;
        bus.rspReady = 1'b0;
        @(negedge clk);
        check("bp_idle_after_handshake", {bus.reqReady, bus.busy}, 2'b10);
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        @(negedge clk);
        check("bp_second_exec", {bus.busy, bus.aluEnable, bus.aluOp}, {1'b1, 1'b1, OP_XOR});
        @(posedge clk);
        @(negedge clk);
        check("bp_second_rsp", {bus.rspValid, bus.rspResult, bus.rspZero, bus.rspCarry},
              {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0});
        #1 bus.rspReady = 1'b1;
        @(posedge clk); #1;
        bus.rspReady = 1'b0;

        // Reset in the middle of a long shift aborts it
        @(posedge clk); #1;
        bus.reqValid = 1'b1; bus.reqOp = OP_SRL; bus.reqA = 32'hDEAD_BEEF; bus.reqShiftCount = 5'd20;
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_async{aluEnable,busy,rspValid}", {bus.aluEnable, bus.busy, bus.rspValid}, 3'b000);
        check("abort_reqReady", bus.reqReady, 1'b1);
        @(negedge clk); #1 reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.rspValid) seen = 1'b1;
        end
        check("abort_no_response", seen, 1'b0);
        run_op(OP_XOR, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0, 0, lat, rsp);
        check("post_reset_xor_latency", lat, 2);
        check("post_reset_xor_rsp", rsp, {32'hFFFF_FFFF, 1'b0, 1'b0});

        // Randomized operations; the per-cycle compare does the checking
        for (int i = 0; i < 120; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(6, 8)) : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0:       n = 5'd0;
                1:       n = 5'd1;
                2:       n = 5'd31;
                default: n = 5'($urandom);
            endcase
            run_op(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, n,
                   $urandom_range(0, 3), lat, rsp);
            check("rand_latency", lat, is_shift(op) ? ((n == 5'd0) ? 1 : int'(n) + 1) : 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-cycle controller in front of the single-cycle `ALU` datapath. It accepts one operation at a time over a valid/ready request port and drives the ALU ports itself. Single-cycle ops (ADD/SUB/AND/OR/XOR/NOT/undefined) complete in one ALU pass. Shifts by an arbitrary 0–31 distance are built by iterating the ALU's 1-bit shift. The ALU result bus is enabled only while this block is issuing, so other drivers may share that bus.

## Interface
- `WIDTH`, 32, operand/result width.
- `CNT_W`, 5, shift-count width (max distance 2^CNT_W−1).

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  block can accept a request.
- `reqOp`  in  4  ALU opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 0110 SLA, 0111 SRA, 1000 SRL, others undefined.
- `reqA`, `reqB`  in  WIDTH  operands.
- `reqShiftCount`  in  CNT_W  shift distance; ignored for non-shift ops.
- `rspValid`  out  1  response present.
- `rspReady`  in  1  consumer takes the response.
- `rspResult`  out  WIDTH  final result.
- `rspZero`, `rspCarry`  out  1  final flags.
- `busy`  out  1  high in any state other than IDLE.
- `aluOperandA`, `aluOperandB`  out  WIDTH  to ALU operands.
- `aluOp`  out  4  to ALU opcode.
- `aluShiftAmount`  out  1  to ALU shift amount.
- `aluEnable`  out  1  to ALU enable (result tri-stated when 0).
- `aluRes`  in  WIDTH  from ALU result.
- `aluZero`, `aluCarry`  in  1  from ALU flags.

## Operation
- FSM states: IDLE, EXEC, SHIFT, DONE.
- IDLE: `reqReady`=1. On `reqValid & reqReady`, latch op, A, B and count.
  - Non-shift op (incl. undefined) → EXEC.
  - Shift op with count≠0 → SHIFT, remaining=count, work=A.
  - Shift op with count=0 → DONE directly: result=A, zero=(A==0), carry=0; the ALU is never enabled.
- EXEC (one cycle):
  - Drive `aluOp`=op, `aluOperandA`=A, `aluOperandB`=B, `aluShiftAmount`=0, `aluEnable`=1.
  - Capture `aluRes`/`aluZero`/`aluCarry` into the rsp registers → DONE.
- SHIFT (one cycle per bit):
  - Drive `aluOp`=op, `aluOperandA`=work, `aluOperandB`=0, `aluShiftAmount`=1, `aluEnable`=1.
  - Update work←`aluRes` and decrement remaining.
  - In the cycle where remaining==1: capture result=`aluRes`, zero=`aluZero`, carry=0, then → DONE.
  - SRA always shifts by exactly one bit in the ALU, which is consistent with driving 1.
- DONE: `rspValid`=1, rsp outputs stable. On `rspReady` → IDLE.
- When not in EXEC/SHIFT, all `alu*` outputs are driven 0.
- `reqReady`=0 in EXEC, SHIFT and DONE. At most one operation is in flight; no request/response overlap.
- Shift semantics:
  - SLA: fill with 0.
  - SRL: fill with 0.
  - SRA: sign-replicating.
  - Count 31 is legal. Bits shifted out are discarded, with no wrap.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: `rspValid`=0, `rspResult`=0, `rspZero`=0, `rspCarry`=0, `busy`=0, all `alu*`=0.
  - `reqReady`=1.
- Reset asserted mid-operation: operation aborts with no response. `aluEnable` drops asynchronously. Latched request data is discarded.
- Latency, with accept at the edge ending cycle 0:
  - Non-shift: EXEC in cycle 1, `rspValid` from cycle 2.
  - Shift count N≥1: SHIFT in cycles 1..N, `rspValid` from cycle N+1.
  - Count 0: `rspValid` from cycle 1.
- Next accept: earliest in the cycle after the `rspValid & rspReady` handshake, since `reqReady` returns only in IDLE.
- Backpressure: `rspResult`/`rspZero`/`rspCarry` are held bit-stable while `rspValid & ~rspReady`.
- `reqValid` outside IDLE is ignored and has no side effect.

## Test plan
- ADD A=0xFFFFFFFF, B=0x00000001 → `aluEnable` high only in cycle 1. `rspValid` in cycle 2 with result 0x00000000, zero=1, carry=1.
- SRL A=0x80000000, count 31 → 31 consecutive cycles of `aluShiftAmount`=1, `aluOp`=1000. `rspValid` in cycle 32 with result 0x00000001, zero=0, carry=0.
- SRA A=0x80000000, count 4 → result 0xF8000000 in cycle 5. SLA A=0x00000001, count 31 → result 0x80000000.
- SLA A=0, count 0 → `rspValid` in cycle 1, result 0, zero=1, carry=0. `aluEnable` never asserted.
- Hold `rspReady` low for 5 cycles with `reqValid` asserted throughout → rsp outputs stable, `reqReady`=0, no second accept. After the handshake, the second request is accepted the following cycle and completes normally.
- SRL count 20, assert `reset` in cycle 10 → `aluEnable`=0 and `busy`=0 immediately, no `rspValid`. After release, an XOR 0xFFFF0000^0x0000FFFF request returns 0xFFFFFFFF in cycle 2.
